// File: rtl/insn_encoder_pkg.sv
// Shared core constants: immediate-format codes, output buffer depth bounds and
// the store opcode prefix, common to this encoder and the decode-side sign extender.
package insn_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_IS = 2'b00,
    IMM_U  = 2'b01,
    IMM_B  = 2'b10,
    IMM_J  = 2'b11
  } imm_src_e;

  localparam int OUT_DEPTH_MIN = 2;
  localparam int OUT_DEPTH_MAX = 8;

  // opcode[6:4] value that distinguishes S-type from I-type under IMM_IS
  localparam logic [2:0] STORE_OP_PREFIX = 3'b010;

endpackage

// File: rtl/insn_fifo.sv
// Small circular output buffer for encoded words; in_ready is derived only from
// registered state, and the read word is forced to zero while the buffer is empty.
module insn_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_live;
  logic             w_push;
  logic             w_pop;

  assign o_ready = r_live && (r_count < CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && o_valid;

  // NOTE: storage has no reset; o_data is gated by o_valid, so stale entries never escape.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/insn_encoder.sv
// RISC-V style instruction encoder: combinational field packing and optional
// immediate range check (enable with IMM_RANGE_CHECK_EN) ahead of an insn_fifo.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  if (OUT_DEPTH < OUT_DEPTH_MIN || OUT_DEPTH > OUT_DEPTH_MAX) begin : g_bad_depth
    $error("insn_encoder: OUT_DEPTH out of range");
  end

  logic [31:0] w_insn;
  logic        w_is_store;
  logic        w_imm_err;
  logic        w_accept;
  logic [32:0] w_rd_data;

  assign w_is_store = (opcode[6:4] == STORE_OP_PREFIX);
  assign w_accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_insn = '0;
    case (imm_src_e'(imm_src))
      IMM_IS: w_insn = w_is_store
                       ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
                       : {imm[11:0], rs1, funct3, rd, opcode};
      IMM_U:  w_insn = {imm[31:12], rd, opcode};
      IMM_B:  w_insn = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      IMM_J:  w_insn = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: w_insn = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic [7:0] r_err_cnt;

  // A field is representable when all bits above its top are copies of its sign.
  always_comb begin
    w_imm_err = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_IS: w_imm_err = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_U:  w_imm_err = (imm[11:0] != 12'd0);
      IMM_B:  w_imm_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      IMM_J:  w_imm_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      default: w_imm_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_err_cnt <= '0;
    else if (w_accept && w_imm_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_cnt = r_err_cnt;
`else
  assign w_imm_err = 1'b0;
  assign err_cnt   = '0;
`endif

  insn_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_data  ({w_imm_err, w_insn}),
    .o_ready (in_ready),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_rd_data)
  );

  assign out_insn = w_rd_data[31:0];
  assign out_err  = w_rd_data[32];

endmodule

// File: tb/tb_insn_encoder.sv
// Directed-vector bench for insn_encoder; expectations adapt to IMM_RANGE_CHECK_EN.
module tb_insn_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RC_EN = 1'b1;
`else
  localparam logic RC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  imm_src;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  insn_encoder #(.OUT_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_src   (imm_src),
    .opcode    (opcode),
    .funct3    (funct3),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] im);
    imm_src = s; opcode = op; funct3 = f3; rd = d; rs1 = r1; rs2 = r2; imm = im;
    in_valid = 1'b1;
  endtask

  // One request with the consumer ready: visible one edge later, gone the edge after.
  task automatic xfer(input string tag, input logic [1:0] s, input logic [6:0] op,
                      input logic [2:0] f3, input logic [4:0] d, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [31:0] im,
                      input logic [31:0] exp_insn, input logic exp_err);
    drive(s, op, f3, d, r1, r2, im);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_insn"}, out_insn, exp_insn);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    step();
    check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = '0; opcode = '0; funct3 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #2;
    check("rst_valid",    {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready},  32'd0);
    check("rst_insn",     out_insn,           32'd0);
    check("rst_err",      {31'd0, out_err},   32'd0);
    check("rst_err_cnt",  {24'd0, err_cnt},   32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rel_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("first_edge_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    xfer("I_addi",  2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    xfer("S_sw",    2'b00, 7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_A423, 1'b0);
    xfer("U_lui",   2'b01, 7'b0110111, 3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    xfer("J_jal",   2'b11, 7'b1101111, 3'b000, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
    xfer("B_beq",   2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_0008, 32'h0020_8463, 1'b0);
    check("err_cnt_clean", {24'd0, err_cnt}, 32'd0);

    xfer("B_range", 2'b10, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'h0000_1000, 32'h8020_8063, RC_EN);
    check("err_cnt_B", {24'd0, err_cnt}, RC_EN ? 32'd1 : 32'd0);
    xfer("J_odd",   2'b11, 7'b1101111, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0000_0003, 32'h0020_006F, RC_EN);
    check("err_cnt_J", {24'd0, err_cnt}, RC_EN ? 32'd2 : 32'd0);

    // Backpressure: three back-to-back requests into a two-entry buffer.
    out_ready = 1'b0;
    drive(2'b00, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'h0000_0001);  // 0x00100093
    step();
    check("bp_ready_1", {31'd0, in_ready}, 32'd1);
    drive(2'b00, 7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 32'h0000_0002);  // 0x00200113
    step();
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    drive(2'b00, 7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 32'h0000_0003);  // 0x00300193
    step();
    step();
    check("bp_hold_insn",  out_insn,            32'h0010_0093);
    check("bp_hold_valid", {31'd0, out_valid},  32'd1);
    check("bp_still_full", {31'd0, in_ready},   32'd0);
    out_ready = 1'b1;
    step();
    check("bp_pop_A_next", out_insn,           32'h0020_0113);
    check("bp_ready_free", {31'd0, in_ready},  32'd1);
    step();
    in_valid = 1'b0;
    check("bp_pop_B_next", out_insn,           32'h0030_0193);
    check("bp_C_valid",    {31'd0, out_valid}, 32'd1);
    step();
    check("bp_empty",      {31'd0, out_valid}, 32'd0);

    // Reset with two entries buffered.
    out_ready = 1'b0;
    drive(2'b01, 7'b0110111, 3'b000, 5'd7, 5'd0, 5'd0, 32'hABCD_E000);
    step();
    step();
    in_valid = 1'b0;
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_insn",  out_insn,           32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd0);
    #3;
    rst_n = 1'b1;
    step();
    check("after_rst_valid", {31'd0, out_valid}, 32'd0);
    check("after_rst_ready", {31'd0, in_ready},  32'd1);
    out_ready = 1'b1;
    step();
    check("after_rst_no_stale", {31'd0, out_valid}, 32'd0);
    xfer("post_rst_U", 2'b01, 7'b0110111, 3'b000, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 2, giving the output buffer entry count (legal values 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, request accepted when in_valid && in_ready at a clock edge.
REQ-006 SHALL have port imm_src, input, 2, immediate format: 00 I/S, 01 U, 10 B, 11 J.
REQ-007 SHALL have ports opcode (input, 7), funct3 (input, 3), rd, rs1 and rs2 (input, 5 each), the non-immediate fields.
REQ-008 SHALL have port imm, input, 32, the signed byte-offset or upper value to encode.
REQ-009 SHALL have port out_valid, output, 1, an encoded word is present.
REQ-010 SHALL have port out_ready, input, 1, the consumer pops when out_valid && out_ready.
REQ-011 SHALL have port out_insn, output, 32, the encoded instruction.
REQ-012 SHALL have ports out_err (output, 1, range violation for out_insn) and err_cnt (output, 8, errors seen).

Function
REQ-013 SHALL place opcode in [6:0] for every format; funct3 in [14:12] and rs1 in [19:15] for I/S/B; rs2 in [24:20] for S/B; rd in [11:7] for I/U/J.
REQ-014 SHALL encode I (imm_src 00, opcode[6:4] != 010): imm[11:0] goes to [31:20].
REQ-015 SHALL encode S (imm_src 00, opcode[6:4] == 010): imm[11:5] goes to [31:25] and imm[4:0] to [11:7].
REQ-016 SHALL encode U: imm[31:12] goes to [31:12].
REQ-017 SHALL encode B: imm[12],imm[10:5] go to [31:25], and imm[4:1],imm[11] go to [11:7].
REQ-018 SHALL encode J: imm[20],imm[10:1],imm[11],imm[19:12] go to [31:12].
REQ-019 SHALL use a registered path: a word accepted at edge N is visible on out_insn with out_valid=1 after edge N when the buffer was empty (latency 1).
REQ-020 SHALL drive in_ready = (count < OUT_DEPTH) with no full-buffer pass-through; in_ready depends only on registered state.
REQ-021 SHALL, on a simultaneous push and pop, keep count unchanged and preserve FIFO order.
REQ-022 SHALL wrap read and write pointers modulo OUT_DEPTH; count has range 0..OUT_DEPTH.
REQ-023 SHALL hold out_insn and out_err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL ignore out_ready when the buffer is empty.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear count and pointers and drive out_valid=0, out_insn=0, out_err=0, err_cnt=0, in_ready=0 (in_ready rises on the first edge after release).
REQ-026 SHALL discard buffered entries when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, with IMM_RANGE_CHECK_EN defined, flag out_err per entry when imm is not representable: I/S when imm[31:11] is not uniform; B when imm[31:12] is not uniform or imm[0]=1; J when imm[31:20] is not uniform or imm[0]=1; U when imm[11:0] != 0.
REQ-028 SHALL, with IMM_RANGE_CHECK_EN defined, increment err_cnt by 1 per accepted erroneous request, saturating at 255; the truncated word is still emitted.
REQ-029 SHALL, without IMM_RANGE_CHECK_EN, tie out_err and err_cnt to 0 and omit the check logic.

Structure
REQ-030 SHALL take the imm_src codes, the OUT_DEPTH bounds and the store opcode-prefix constant (010) from the shared core package used by the decode-side sign extender.
REQ-031 SHALL use one sub-module, insn_fifo, for the buffer; encoding and range check SHALL stay combinational in insn_encoder ahead of the push.

Verification
REQ-032 SHALL cover I: opcode 0010011, funct3 0, rd 1, rs1 0, imm 0xFFFFFFFF -> out_insn 0xFFF00093 one cycle later, out_err 0.
REQ-033 SHALL cover S: opcode 0100011, funct3 010, rs1 1, rs2 2, imm 8 -> 0x0020A423.
REQ-034 SHALL cover U and J: lui rd 5, imm 0x12345000 -> 0x123452B7; jal rd 0, imm 0xFFFFFFFC -> 0xFFDFF06F.
REQ-035 SHALL cover range (macro on): B imm 0x00001000 -> out_err 1, err_cnt 1; J imm 3 -> out_err 1, err_cnt 2.
REQ-036 SHALL cover backpressure: out_ready 0, three back-to-back requests (OUT_DEPTH 2) -> in_ready 0 after two; out_ready 1 -> first two drained in order, third accepted, none lost.
REQ-037 SHALL cover reset: assert rst_n low with 2 entries buffered -> out_valid 0 immediately and no stale word after release.
